hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard-detection and forwarding scoreboard for the pipelined RISC-V core. It sits beside the decode stage and keeps a shift-register shadow of the destination registers in flight in the DEPTH stages after decode. Per-operand forwarding selects and the load-use stall are derived from that shadow rather than from fixed execute/memory ports. It generalises the core's fixed two-stage hazard logic in three ways: configurable pipeline depth, configurable load latency, and freeze/flush handling, plus a saturating stall-cycle counter.

## Interface
- DEPTH, 2: number of post-decode stages tracked. Stage 1 is execute; stage DEPTH is the last stage before register-file write. Legal values are 2..6.
- LOAD_LATENCY, 1: a load's data can be forwarded only once the load reaches stage LOAD_LATENCY+1. Must satisfy 1 <= LOAD_LATENCY < DEPTH.
- ADDR_WIDTH, 5: register index width.
- CNT_WIDTH, 16: width of the stall counter.
- SEL_WIDTH, $clog2(DEPTH+1): width of the forwarding selects (derived).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- id_valid, input, 1: the decode stage holds a real instruction.
- id_rs1 / id_rs2, input, ADDR_WIDTH: source register indices.
- id_rs1_used / id_rs2_used, input, 1: the instruction actually reads that source. From the control unit; for example, U/J types read neither, I type reads rs1 only.
- id_rd, input, ADDR_WIDTH: destination register index.
- id_reg_write, input, 1: the instruction writes id_rd.
- id_is_load, input, 1: the instruction is a load.
- flush, input, 1: the decode instruction is killed by the branch/jump unit.
- freeze, input, 1: the whole pipeline is held, e.g. while memory is busy.
- stall, output, 1: hold fetch/decode and insert a bubble into execute.
- rs1_fwd_sel / rs2_fwd_sel, output, SEL_WIDTH: 0 selects the register file; k selects the result of stage k (1..DEPTH).
- stall_count, output, CNT_WIDTH: saturating count of stall cycles.

## Operation
- **State.** The scoreboard holds DEPTH entries, entry[k] = {valid, rd, is_load}, with k = 1..DEPTH.
- **Source match.** A source s "matches" stage k when all of the following hold:
  - id_valid;
  - s is used;
  - s != 0;
  - entry[k].valid;
  - entry[k].rd == s.
- **Priority.** The youngest (smallest k) match decides. Older matches are ignored, because they hold stale values.
- **Ready rule.** The youngest match is "not ready" if entry[k].is_load and k <= LOAD_LATENCY.
- **stall.** Asserted when either source's youngest match is not ready. Forced to 0 when flush is asserted.
- **fwd_sel.** Equals k of the youngest match, else 0. Register x0 always gives 0.
- **Write-through.** A value that has left stage DEPTH is assumed to be written to the register file in time to be read (write-first register file). No match exists beyond DEPTH.
- **Update on each rising edge when rst=0 and freeze=0:**
  - entry[k] <= entry[k-1] for k = 2..DEPTH.
  - entry[1] <= {1, id_rd, id_is_load} if id_valid && id_reg_write && id_rd != 0 && !stall && !flush.
  - Otherwise entry[1] <= invalid (bubble).
- **freeze=1.** All entries and stall_count hold. Outputs stay combinationally valid against the held state.
- **stall_count.** Increments by 1 on each edge where stall && !freeze. It saturates at all-ones and never wraps.
- **Reset.** Clears all entries to invalid and stall_count to 0.
  - Consequence: stall=0 and both fwd_sel=0 in the cycle after reset, regardless of the decode inputs.
  - Reset asserted mid-stall cancels the pending hazard.
- **Simultaneous events.**
  - flush overrides stall: the killed instruction is never pushed.
  - freeze with flush: no state change; flush only masks stall.
  - rst overrides freeze.

## Timing
- stall and fwd_sel are combinational from the decode inputs plus the registered scoreboard; there are no registered outputs.
- Scoreboard and stall_count have 1-cycle update latency.
- A load-use pair stalls for exactly LOAD_LATENCY+1-d cycles, where d is the instruction distance between them. For d=1 that is LOAD_LATENCY cycles; for d > LOAD_LATENCY there is no stall.
- The maximum number of consecutive stall cycles without freeze is LOAD_LATENCY.

## Test plan
- **ALU back-to-back (DEPTH=2, LOAD_LATENCY=1).** add x5 then sub x6,x5,x5 → stall=0, rs1_fwd_sel=rs2_fwd_sel=1. One cycle later, an unrelated instruction reading x5 gets fwd_sel=2. Two cycles later it gets fwd_sel=0.
- **Load-use.** lw x7 then add x8,x7,x0 → stall=1 for 1 cycle, stall_count=1. The next cycle gives stall=0, rs1_fwd_sel=2, rs2_fwd_sel=0. With LOAD_LATENCY=2 and DEPTH=3, the same pair gives 2 stall cycles and then rs1_fwd_sel=3.
- **Youngest-match priority.** add x5 then addi x5 then or x9,x5 → rs1_fwd_sel=1, not 2. Also: a write to x0 followed by a read of x0 → fwd_sel=0, stall=0.
- **Flush and freeze.** A load-use pair with flush=1 on the consumer → stall=0 and the consumer is not pushed. Holding freeze=1 for 3 cycles during a load-use stall → stall remains 1, stall_count unchanged, entries unchanged. After release the stall resolves normally.
- **Counter saturation and reset (CNT_WIDTH=4).** 20 stall cycles → stall_count=15. Assert rst mid-stall → the next cycle gives stall_count=0, stall=0, and all entries invalid.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard-detection and forwarding scoreboard beside decode: tracks destination registers in
// flight for DEPTH post-decode stages and derives per-operand forwarding and load-use stalls.
module hazard_scoreboard #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned SEL_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  flush,
    input  logic                  freeze,
    output logic                  stall,
    output logic [SEL_WIDTH-1:0]  rs1_fwd_sel,
    output logic [SEL_WIDTH-1:0]  rs2_fwd_sel,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    logic [DEPTH:1]        valid_q, valid_d;
    logic [DEPTH:1]        load_q, load_d;
    logic [ADDR_WIDTH-1:0] rd_q [1:DEPTH];
    logic [ADDR_WIDTH-1:0] rd_d [1:DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [SEL_WIDTH-1:0]  rs1_sel, rs2_sel;
    logic                  rs1_wait, rs2_wait;
    logic                  push;

    // Scan oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        rs1_sel  = '0;
        rs2_sel  = '0;
        rs1_wait = 1'b0;
        rs2_wait = 1'b0;
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            if (id_valid && id_rs1_used && (id_rs1 != '0) && valid_q[k] && (rd_q[k] == id_rs1)) begin
                rs1_sel  = SEL_WIDTH'(k);
                rs1_wait = load_q[k] && (k <= LOAD_LATENCY);
            end
            if (id_valid && id_rs2_used && (id_rs2 != '0) && valid_q[k] && (rd_q[k] == id_rs2)) begin
                rs2_sel  = SEL_WIDTH'(k);
                rs2_wait = load_q[k] && (k <= LOAD_LATENCY);
            end
        end
    end

    assign stall       = (rs1_wait || rs2_wait) && !flush;
    assign push        = id_valid && id_reg_write && (id_rd != '0) && !stall && !flush;
    assign rs1_fwd_sel = rs1_sel;
    assign rs2_fwd_sel = rs2_sel;
    assign stall_count = cnt_q;

    always_comb begin
        valid_d = valid_q;
        load_d  = load_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                load_d[k]  = load_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
            valid_d[1] = push;
            load_d[1]  = push && id_is_load;
            rd_d[1]    = push ? id_rd : '0;
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            load_q  <= '0;
            rd_q    <= '{default: '0};
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: DEPTH=2/LOAD_LATENCY=1 with a 4-bit counter, and
// DEPTH=3/LOAD_LATENCY=2 for the longer load-use stall.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
    logic       flush, freeze;

    logic       a_stall;
    logic [1:0] a_rs1_sel, a_rs2_sel;
    logic [3:0] a_cnt;

    logic        b_stall;
    logic [1:0]  b_rs1_sel, b_rs2_sel;
    logic [15:0] b_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .DEPTH(2), .LOAD_LATENCY(1), .ADDR_WIDTH(5), .CNT_WIDTH(4)
    ) u_dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush), .freeze(freeze),
        .stall(a_stall), .rs1_fwd_sel(a_rs1_sel), .rs2_fwd_sel(a_rs2_sel), .stall_count(a_cnt)
    );

    hazard_scoreboard #(
        .DEPTH(3), .LOAD_LATENCY(2), .ADDR_WIDTH(5), .CNT_WIDTH(16)
    ) u_dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush), .freeze(freeze),
        .stall(b_stall), .rs1_fwd_sel(b_rs1_sel), .rs2_fwd_sel(b_rs2_sel), .stall_count(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
        id_valid     = 1'b1;
        id_rs1       = rs1;
        id_rs1_used  = u1;
        id_rs2       = rs2;
        id_rs2_used  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        freeze = 1'b0;
        // Garbage decode inputs during reset must not matter.
        instr(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("reset_stall", a_stall, 0);
        check_eq("reset_sel1", a_rs1_sel, 0);
        check_eq("reset_sel2", a_rs2_sel, 0);
        check_eq("reset_cnt", a_cnt, 0);
        check_eq("reset_cnt_b", b_cnt, 0);

        // ALU back-to-back: add x5,x1,x2 ; sub x6,x5,x5 ; reader of x5 twice
        instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        instr(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        check_eq("alu_stall", a_stall, 0);
        check_eq("alu_sel1", a_rs1_sel, 1);
        check_eq("alu_sel2", a_rs2_sel, 1);
        tick();
        instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        check_eq("alu_d2_sel1", a_rs1_sel, 2);
        tick();
        // lw x7,0(x5): x5 has left the pipeline
        instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        check_eq("alu_d3_sel1", a_rs1_sel, 0);
        check_eq("alu_d3_stall", a_stall, 0);
        tick();

        // Load-use: add x8,x7,x0
        instr(5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        check_eq("lu_stall", a_stall, 1);
        check_eq("lu_sel1", a_rs1_sel, 1);
        tick();
        check_eq("lu_resolved_stall", a_stall, 0);
        check_eq("lu_resolved_sel1", a_rs1_sel, 2);
        check_eq("lu_resolved_sel2", a_rs2_sel, 0);
        check_eq("lu_cnt", a_cnt, 1);
        tick();

        // Youngest-match priority: add x5 ; addi x5,x5 ; or x9,x5,x0
        instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        instr(5'd5, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        check_eq("prio_sel1", a_rs1_sel, 1);
        tick();
        // Load targeting x0 followed by reads of x0
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0);
        check_eq("x0_sel1", a_rs1_sel, 0);
        check_eq("x0_sel2", a_rs2_sel, 0);
        check_eq("x0_stall", a_stall, 0);

        // Flush on the consumer of a load
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check_eq("flush_stall", a_stall, 0);
        tick();
        flush = 1'b0;
        instr(5'd8, 1'b1, 5'd7, 1'b1, 5'd12, 1'b1, 1'b0);
        check_eq("flush_not_pushed", a_rs1_sel, 0);
        check_eq("flush_load_sel2", a_rs2_sel, 2);
        check_eq("flush_cnt", a_cnt, 1);

        // Freeze held for 3 cycles during a load-use stall
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("frz_stall", a_stall, 1);
            check_eq("frz_sel1", a_rs1_sel, 1);
            check_eq("frz_cnt", a_cnt, 1);
        end
        freeze = 1'b0;
        #1;
        check_eq("frz_release_stall", a_stall, 1);
        tick();
        check_eq("post_frz_stall", a_stall, 0);
        check_eq("post_frz_sel1", a_rs1_sel, 2);
        check_eq("post_frz_cnt", a_cnt, 2);

        // lw x7,0(x7) held: stalls on every other edge; 20 stalls saturate the 4-bit counter
        instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 41; i++) tick();
        check_eq("sat_stall", a_stall, 1);
        check_eq("sat_cnt", a_cnt, 15);

        // Reset mid-stall cancels the hazard
        instr(5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_cnt", a_cnt, 0);
        check_eq("rst_stall", a_stall, 0);
        check_eq("rst_sel1", a_rs1_sel, 0);
        check_eq("rst_sel2", a_rs2_sel, 0);

        // DEPTH=3, LOAD_LATENCY=2 instance: lw x7 ; add x8,x7,x0
        check_eq("b_rst_cnt", b_cnt, 0);
        instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        instr(5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        check_eq("b_lu_stall0", b_stall, 1);
        check_eq("b_lu_sel0", b_rs1_sel, 1);
        tick();
        check_eq("b_lu_stall1", b_stall, 1);
        check_eq("b_lu_sel1", b_rs1_sel, 2);
        check_eq("b_lu_cnt1", b_cnt, 1);
        tick();
        check_eq("b_lu_stall2", b_stall, 0);
        check_eq("b_lu_sel2", b_rs1_sel, 3);
        check_eq("b_lu_sel2_rs2", b_rs2_sel, 0);
        check_eq("b_lu_cnt2", b_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
